fa_self_checker: RTL and testbench
==================================

FA_SELF_CHECKER -- requirements
Module: fa_self_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles between driving a vector and sampling the adder response. Legal range 0..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one exhaustive check run.
REQ-005 SHALL have ports fa_a, fa_b and fa_c, outputs, 1 bit each: registered stimulus to the full adder under test (a, b, carry-in).
REQ-006 SHALL have ports fa_sum and fa_cout, inputs, 1 bit each: adder response.
REQ-007 SHALL have port busy, output, 1 bit: run in progress.
REQ-008 SHALL have port done, output, 1 bit: run complete; held until the next accepted start or reset.
REQ-009 SHALL have port pass, output, 1 bit: valid while done=1; 1 when there were zero mismatches.
REQ-010 SHALL have port err_count, output, 4 bits: mismatching vectors in the last run, 0..8.
REQ-011 SHALL have port first_fail_idx, output, 3 bits: index of the first mismatching vector; valid when done=1 and pass=0.

Function
REQ-012 SHALL implement the FSM states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in any other state SHALL be ignored.
REQ-014 On an accepted start, SHALL clear idx, err_count, first_fail_idx, done and pass; set busy=1; and go to DRIVE.
REQ-015 In DRIVE, SHALL register fa_a=idx[2], fa_b=idx[1] and fa_c=idx[0], giving vector order 000,001,...,111.
REQ-016 SHALL go from DRIVE to SETTLE for exactly SETTLE_CYCLES cycles, then to CHECK; with SETTLE_CYCLES=0 it SHALL go from DRIVE directly to CHECK.
REQ-017 In CHECK, SHALL compare {fa_cout,fa_sum} against a golden sum of the three current stimulus bits (2-bit result).
REQ-018 On a mismatch in CHECK, SHALL increment err_count, and SHALL capture idx into first_fail_idx only on the first mismatch of the run.
REQ-019 From CHECK, SHALL go to DRIVE with idx+1 if idx<7; if idx==7 it SHALL go to DONE with no idx wrap-around used.
REQ-020 In DONE, SHALL set busy=0, done=1 and pass=(err_count==0), and SHALL hold fa_a, fa_b and fa_c at their last values.
REQ-021 Run latency SHALL be 8*(SETTLE_CYCLES+2) cycles, counted from the clock edge that accepts start to the edge that asserts done.
REQ-022 An accepted start in DONE SHALL begin a new run on the same edge.

Reset
REQ-023 When rst_n is low, SHALL asynchronously force state=IDLE and clear idx and the settle counter.
REQ-024 When rst_n is low, SHALL force fa_a=fa_b=fa_c=0, busy=0, done=0, pass=0, err_count=0 and first_fail_idx=0.
REQ-025 Reset asserted mid-run SHALL abort the run with no partial results retained.
REQ-026 SHALL leave reset synchronously to clk, taking effect from the first clock edge after rst_n rises.

Configuration
REQ-027 With FA_CHECKER_STOP_ON_FAIL_EN defined, the first mismatch in CHECK SHALL go directly to DONE, with err_count=1 and first_fail_idx equal to the failing index.
REQ-028 With FA_CHECKER_STOP_ON_FAIL_EN undefined, all 8 vectors SHALL always be checked.

Structure
REQ-029 Package fa_check_pkg SHALL hold the FSM state enum typedef, the constant NUM_VECTORS=8 and the index width constant 3.
REQ-030 The golden model SHALL be the sub-module fa_ref_model, purely combinational: inputs a, b, c; outputs sum, cout.

Verification
REQ-031 The bench SHALL apply a correct adder with SETTLE_CYCLES=2 and start pulsed, and see done rise 32 cycles later, pass=1, err_count=0.
REQ-032 The bench SHALL apply an adder with cout stuck at 0 and see pass=0, err_count=4 and first_fail_idx=3.
REQ-033 The bench SHALL apply an adder with sum inverted and see err_count=8 and first_fail_idx=0.
REQ-034 The bench SHALL drop rst_n low during vector 5 of a run and see all outputs 0 and the FSM in IDLE immediately; a fresh start SHALL then give a full run of 32 cycles.
REQ-035 The bench SHALL pulse start during SETTLE and see it ignored, with the run completing in the original 32 cycles.
REQ-036 The bench SHALL build with FA_CHECKER_STOP_ON_FAIL_EN defined and sum inverted at idx 2 only, and see done after 12 cycles, err_count=1 and first_fail_idx=2.

Source files
------------

// File: rtl/fa_check_pkg.sv
// Shared types and constants for the full-adder self-checker.
// State enum, vector count and index width.
package fa_check_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/fa_ref_model.sv
// Golden full adder used to judge the adder under test.
// Purely combinational.
module fa_ref_model (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fa_self_checker.sv
// Exhaustive self-checker for an external full adder (8 vectors).
// Define FA_CHECKER_STOP_ON_FAIL_EN to end a run at the first mismatch.
module fa_self_checker
    import fa_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       fa_a,
    output logic       fa_b,
    output logic       fa_c,
    input  logic       fa_sum,
    input  logic       fa_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_idx
);

    localparam logic [3:0] LP_SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_cnt;
    logic             r_fa_a;
    logic             r_fa_b;
    logic             r_fa_c;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_err;
    logic [IDX_W-1:0] r_ffi;

    logic w_ref_sum;
    logic w_ref_cout;
    logic w_start_ok;
    logic w_mismatch;
    logic w_last;
    logic w_finish;

    fa_ref_model u_ref (
        .a    (r_fa_a),
        .b    (r_fa_b),
        .c    (r_fa_c),
        .sum  (w_ref_sum),
        .cout (w_ref_cout)
    );

    assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
    assign w_mismatch = (r_state == CHECK) &&
                        ({fa_cout, fa_sum} != {w_ref_cout, w_ref_sum});
    assign w_last     = (r_idx == IDX_W'(NUM_VECTORS - 1));

`ifdef FA_CHECKER_STOP_ON_FAIL_EN
    assign w_finish = w_last || w_mismatch;
`else
    assign w_finish = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:   if (start) w_next = DRIVE;
            DRIVE:  w_next = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
            SETTLE: if (r_cnt == LP_SETTLE_LAST) w_next = CHECK;
            CHECK:  w_next = w_finish ? DONE : DRIVE;
            DONE:   if (start) w_next = DRIVE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_fa_a <= 1'b0;
            r_fa_b <= 1'b0;
            r_fa_c <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_ffi  <= '0;
        end else if (w_start_ok) begin
            r_idx  <= '0;
            r_err  <= '0;
            r_ffi  <= '0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_busy <= 1'b1;
        end else begin
            case (r_state)
                DRIVE: begin
                    r_fa_a <= r_idx[2];
                    r_fa_b <= r_idx[1];
                    r_fa_c <= r_idx[0];
                    r_cnt  <= '0;
                end
                SETTLE: r_cnt <= r_cnt + 4'd1;
                CHECK: begin
                    if (w_mismatch) begin
                        r_err <= r_err + 4'd1;
                        if (r_err == 4'd0) r_ffi <= r_idx;
                    end
                    // No increment on the final vector: idx never wraps
                    if (w_finish) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_err == 4'd0) && !w_mismatch;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fa_a           = r_fa_a;
    assign fa_b           = r_fa_b;
    assign fa_c           = r_fa_c;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_idx = r_ffi;

endmodule

// File: tb/tb_fa_self_checker.sv
// Scoreboard bench for fa_self_checker with a fault-injectable adder.
// Expected run results come from an arithmetic model of the faulty adder.
module tb_fa_self_checker;
    import fa_check_pkg::*;

    localparam int S   = 2;
    localparam int LAT = 8 * (S + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       fa_a, fa_b, fa_c;
    logic       fa_sum, fa_cout;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_idx;

    logic [7:0] sum_flip = 8'h00;
    logic [7:0] cout_flip = 8'h00;
    logic       cout_stuck0 = 1'b0;
    logic [1:0] w_s;
    logic [2:0] w_v;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic done_q = 1'b0;

    typedef struct {
        int lat;
        int pass;
        int err;
        int ffi;
    } exp_t;

    exp_t sb[$];
    int   t_acc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fa_self_checker #(.SETTLE_CYCLES(S)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .fa_a           (fa_a),
        .fa_b           (fa_b),
        .fa_c           (fa_c),
        .fa_sum         (fa_sum),
        .fa_cout        (fa_cout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_idx (first_fail_idx)
    );

    // Adder under test with per-vector fault injection
    assign w_v     = {fa_a, fa_b, fa_c};
    assign w_s     = 2'(fa_a) + 2'(fa_b) + 2'(fa_c);
    assign fa_sum  = w_s[0] ^ sum_flip[w_v];
    assign fa_cout = cout_stuck0 ? 1'b0 : (w_s[1] ^ cout_flip[w_v]);

    function automatic exp_t predict();
        exp_t e;
        int   err = 0;
        int   first = -1;
        for (int v = 0; v < 8; v++) begin
            int good = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            int gs = (good % 2) ^ int'(sum_flip[v]);
            int gc = cout_stuck0 ? 0 : ((good / 2) ^ int'(cout_flip[v]));
            if (gc * 2 + gs != good) begin
                err++;
                if (first < 0) first = v;
`ifdef FA_CHECKER_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        e.err  = err;
        e.pass = (err == 0) ? 1 : 0;
        e.ffi  = (first < 0) ? 0 : first;
        e.lat  = LAT;
`ifdef FA_CHECKER_STOP_ON_FAIL_EN
        if (first >= 0) e.lat = (first + 1) * (S + 2);
`endif
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    int   t;
                    e = sb.pop_front();
                    t = t_acc.pop_front();
                    chk("latency", cyc - t, e.lat);
                    chk("pass", int'(pass), e.pass);
                    chk("err_count", int'(err_count), e.err);
                    chk("first_fail_idx", int'(first_fail_idx), e.ffi);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
            done_q = done;
        end
    end

    task automatic start_run();
        sb.push_back(predict());
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t_acc.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
            t_acc.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fa"}, int'({fa_a, fa_b, fa_c}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_ffi"}, int'(first_fail_idx), 0);
        chk({tag, "_state"}, int'(dut.r_state), int'(IDLE));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        start_run();
        @(negedge clk);
        chk("busy_running", int'(busy), 1);
        wait_drain();

        cout_stuck0 = 1'b1;
        start_run();
        wait_drain();
        cout_stuck0 = 1'b0;

        sum_flip = 8'hFF;
        start_run();
        wait_drain();
        sum_flip = 8'h00;

        // Abort during vector 5, then a clean full run
        start_run();
        repeat (5 * (S + 2) + 1) @(negedge clk);
        chk("vec5_idx", int'(dut.r_idx), 5);
        rst_n = 1'b0;
        sb.delete();
        t_acc.delete();
        #1;
        chk_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run();
        wait_drain();

        // Start pulsed while settling must be ignored
        start_run();
        @(negedge clk);
        chk("in_settle", int'(dut.r_state), int'(SETTLE));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        sum_flip = 8'b0000_0100;
        start_run();
        wait_drain();
        sum_flip = 8'h00;

        for (int i = 0; i < 20; i++) begin
            sum_flip    = (i % 4 == 0) ? 8'h00 : 8'($urandom);
            cout_flip   = (i % 3 == 0) ? 8'h00 : 8'($urandom);
            cout_stuck0 = ($urandom_range(0, 5) == 0);
            start_run();
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
